// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx: DVP camera-sensor emulator driving pclk/vsync/href/data with a synthetic frame pattern.
// Optional build macro DVP_TX_COLORBAR_EN swaps the default ramp for 8 RGB565 vertical colour bars.
module cam_dvp_tx #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int H_BLANK   = 144,
   parameter int VSYNC_LEN = 3,
   parameter int V_BACK    = 17,
   parameter int V_FRONT   = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        single_shot,
   output logic        pclk,
   output logic        cam_vsync,
   output logic        cam_href,
   output logic [7:0]  cam_data,
   output logic        frame_start,
   output logic        frame_done,
   output logic        busy,
   output logic [15:0] frame_count
);

   localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
   localparam int ACT_BYTES = 2 * H_ACTIVE;
   localparam int MAX_AB    = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
   localparam int MAX_SF    = (VSYNC_LEN > V_FRONT) ? VSYNC_LEN : V_FRONT;
   localparam int MAX_LINES = (MAX_AB > MAX_SF) ? MAX_AB : MAX_SF;
   localparam int B_W       = $clog2(LINE_LEN + 1);
   localparam int L_W       = $clog2(MAX_LINES + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VSYNC  = 3'd1,
      S_VBACK  = 3'd2,
      S_ACTIVE = 3'd3,
      S_VFRONT = 3'd4
   } state_t;

   state_t           state_r;
   logic [B_W-1:0]   b_r;
   logic [L_W-1:0]   line_r;
   logic             pclk_r;
   logic             pending_r;
   logic             vsync_r;
   logic             href_r;
   logic [7:0]       data_r;
   logic             frame_start_r;
   logic             frame_done_r;
   logic             busy_r;
   logic [15:0]      frame_count_r;

   state_t           state_nx_s;
   logic [B_W-1:0]   b_nx_s;
   logic [L_W-1:0]   line_nx_s;
   logic [L_W-1:0]   lines_in_state_s;
   logic             line_end_s;
   logic             blk_end_s;
   logic             frame_end_s;
   logic             pend_now_s;
   logic             go_s;
   logic             start_s;
   logic             href_nx_s;
   logic [7:0]       pattern_s;
   logic [7:0]       data_nx_s;

`ifdef DVP_TX_COLORBAR_EN
   function automatic logic [7:0] bar_byte(input logic [B_W-1:0] b);
      logic [2:0]  idx;
      logic [15:0] rgb;
      idx = 3'((b >> 1) / B_W'(H_ACTIVE / 8));
      case (idx)
         3'd0:    rgb = 16'hFFFF;
         3'd1:    rgb = 16'hFFE0;
         3'd2:    rgb = 16'h07FF;
         3'd3:    rgb = 16'h07E0;
         3'd4:    rgb = 16'hF81F;
         3'd5:    rgb = 16'hF800;
         3'd6:    rgb = 16'h001F;
         default: rgb = 16'h0000;
      endcase
      return b[0] ? rgb[7:0] : rgb[15:8];
   endfunction
`endif

   // Line budget of the current state and the end-of-line / end-of-block / end-of-frame flags.
   always_comb begin
      case (state_r)
         S_VSYNC:  lines_in_state_s = L_W'(VSYNC_LEN);
         S_VBACK:  lines_in_state_s = L_W'(V_BACK);
         S_ACTIVE: lines_in_state_s = L_W'(V_ACTIVE);
         S_VFRONT: lines_in_state_s = L_W'(V_FRONT);
         default:  lines_in_state_s = L_W'(1);
      endcase
      line_end_s  = (b_r == B_W'(LINE_LEN - 1));
      blk_end_s   = line_end_s && (line_r == lines_in_state_s - L_W'(1));
      frame_end_s = blk_end_s &&
                    ((state_r == S_VFRONT) || ((state_r == S_ACTIVE) && (V_FRONT == 0)));
      pend_now_s  = pending_r | single_shot;
      go_s        = enable | pend_now_s;
      start_s     = go_s && ((state_r == S_IDLE) || frame_end_s);
   end

   // Next raster position; outputs are registered from it so they match the stored position.
   always_comb begin
      state_nx_s = state_r;
      b_nx_s     = b_r;
      line_nx_s  = line_r;
      if (state_r == S_IDLE) begin
         if (go_s) begin
            state_nx_s = S_VSYNC;
            b_nx_s     = {B_W{1'b0}};
            line_nx_s  = {L_W{1'b0}};
         end else begin
            state_nx_s = S_IDLE;
         end
      end else if (line_end_s) begin
         b_nx_s = {B_W{1'b0}};
         if (blk_end_s) begin
            line_nx_s = {L_W{1'b0}};
            case (state_r)
               S_VSYNC:  state_nx_s = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
               S_VBACK:  state_nx_s = S_ACTIVE;
               S_ACTIVE: state_nx_s = (V_FRONT > 0) ? S_VFRONT : (go_s ? S_VSYNC : S_IDLE);
               S_VFRONT: state_nx_s = go_s ? S_VSYNC : S_IDLE;
               default:  state_nx_s = S_IDLE;
            endcase
         end else begin
            line_nx_s = line_r + L_W'(1);
         end
      end else begin
         b_nx_s = b_r + B_W'(1);
      end
   end

   // Pixel byte for the next position; forced to zero outside the active window.
   always_comb begin
      href_nx_s = (state_nx_s == S_ACTIVE) && (b_nx_s < B_W'(ACT_BYTES));
`ifdef DVP_TX_COLORBAR_EN
      pattern_s = bar_byte(b_nx_s);
`else
      pattern_s = 8'(32'(line_nx_s) + 32'(b_nx_s));
`endif
      if (href_nx_s) begin
         data_nx_s = pattern_s;
      end else begin
         data_nx_s = 8'h00;
      end
   end

   // Frame FSM: pclk divider every clk, raster state and outputs only on ticks (pclk high).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= S_IDLE;
         b_r           <= {B_W{1'b0}};
         line_r        <= {L_W{1'b0}};
         pclk_r        <= 1'b0;
         pending_r     <= 1'b0;
         vsync_r       <= 1'b0;
         href_r        <= 1'b0;
         data_r        <= 8'h00;
         frame_start_r <= 1'b0;
         frame_done_r  <= 1'b0;
         busy_r        <= 1'b0;
         frame_count_r <= 16'h0000;
      end else begin
         pclk_r        <= ~pclk_r;
         frame_start_r <= 1'b0;
         frame_done_r  <= 1'b0;
         if (pclk_r) begin
            state_r       <= state_nx_s;
            b_r           <= b_nx_s;
            line_r        <= line_nx_s;
            vsync_r       <= (state_nx_s == S_VSYNC);
            href_r        <= href_nx_s;
            data_r        <= data_nx_s;
            busy_r        <= (state_nx_s != S_IDLE);
            frame_start_r <= start_s;
            frame_done_r  <= frame_end_s;
            pending_r     <= start_s ? 1'b0 : pend_now_s;
            if (frame_end_s) begin
               frame_count_r <= frame_count_r + 16'd1;
            end else begin
               frame_count_r <= frame_count_r;
            end
         end else begin
            pending_r <= pend_now_s;
         end
      end
   end

   assign pclk        = pclk_r;
   assign cam_vsync   = vsync_r;
   assign cam_href    = href_r;
   assign cam_data    = data_r;
   assign frame_start = frame_start_r;
   assign frame_done  = frame_done_r;
   assign busy        = busy_r;
   assign frame_count = frame_count_r;

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Bench for cam_dvp_tx: directed scenarios plus random enable/shot traffic against a frame-position model.
// Honours DVP_TX_COLORBAR_EN for the expected pixel pattern.
module tb_cam_dvp_tx;

   localparam int H_ACTIVE    = 8;
   localparam int V_ACTIVE    = 3;
   localparam int H_BLANK     = 2;
   localparam int VSYNC_LEN   = 1;
   localparam int V_BACK      = 1;
   localparam int V_FRONT     = 1;
   localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
   localparam int FRAME_LINES = VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT;
   localparam int FRAME_TICKS = FRAME_LINES * LINE_LEN;

   logic        clk = 1'b0;
   logic        reset, enable, single_shot;
   logic        pclk, cam_vsync, cam_href, frame_start, frame_done, busy;
   logic [7:0]  cam_data;
   logic [15:0] frame_count;

   cam_dvp_tx #(
      .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
      .VSYNC_LEN(VSYNC_LEN), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .single_shot(single_shot),
      .pclk(pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
      .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // model: tick index within the current frame (-1 = idle)
   int          m_k = -1;
   bit          m_pclk, m_pend, m_start, m_done;
   logic [15:0] m_count;

   int         cyc = 0;
   int         n_starts, n_dones, vs_clks, href_clks, last_start_cyc, last_done_cyc;
   int         gaps[$];
   logic [7:0] bytes_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [7:0] pattern(input int row, input int b);
      logic [7:0]  r;
      logic [15:0] w;
      r = 8'((row + b) % 256);
`ifdef DVP_TX_COLORBAR_EN
      case ((b / 2) / (H_ACTIVE / 8))
         0:       w = 16'hFFFF;
         1:       w = 16'hFFE0;
         2:       w = 16'h07FF;
         3:       w = 16'h07E0;
         4:       w = 16'hF81F;
         5:       w = 16'hF800;
         6:       w = 16'h001F;
         default: w = 16'h0000;
      endcase
      r = (b % 2 == 0) ? w[15:8] : w[7:0];
`endif
      return r;
   endfunction

   function automatic logic [31:0] dut_vec();
      return {2'b00, pclk, cam_vsync, cam_href, cam_data, frame_start, frame_done, busy, frame_count};
   endfunction

   function automatic logic [31:0] exp_vec();
      logic       vs, hr;
      logic [7:0] d;
      int         line, b;
      vs = 1'b0; hr = 1'b0; d = 8'h00;
      if (m_k >= 0) begin
         line = m_k / LINE_LEN;
         b    = m_k % LINE_LEN;
         vs   = (line < VSYNC_LEN);
         if (line >= VSYNC_LEN + V_BACK && line < VSYNC_LEN + V_BACK + V_ACTIVE && b < 2 * H_ACTIVE) begin
            hr = 1'b1;
            d  = pattern(line - VSYNC_LEN - V_BACK, b);
         end
      end
      return {2'b00, m_pclk, vs, hr, d, m_start, m_done, (m_k >= 0), m_count};
   endfunction

   task automatic clear_stats();
      n_starts = 0; n_dones = 0; vs_clks = 0; href_clks = 0;
      last_start_cyc = -1; last_done_cyc = -1;
      gaps.delete(); bytes_q.delete();
   endtask

   // one clk: advance the model on the edge, compare every output half a period later
   task automatic step();
      bit pend;
      @(posedge clk);
      if (reset) begin
         m_k = -1; m_pclk = 1'b0; m_pend = 1'b0; m_start = 1'b0; m_done = 1'b0; m_count = 16'h0000;
      end else begin
         m_start = 1'b0; m_done = 1'b0;
         pend = m_pend | single_shot;
         if (m_pclk) begin
            if (m_k >= 0 && m_k < FRAME_TICKS - 1) begin
               m_k++;
            end else begin
               if (m_k == FRAME_TICKS - 1) begin
                  m_done  = 1'b1;
                  m_count = m_count + 16'd1;
               end
               if (enable || pend) begin
                  m_k = 0; m_start = 1'b1; pend = 1'b0;
               end else begin
                  m_k = -1;
               end
            end
         end
         m_pclk = !m_pclk;
         m_pend = pend;
      end
      @(negedge clk);
      cyc++;
      check("outputs", dut_vec(), exp_vec());
      if (frame_start === 1'b1) begin
         n_starts++;
         if (last_start_cyc >= 0) gaps.push_back(cyc - last_start_cyc);
         last_start_cyc = cyc;
      end
      if (frame_done === 1'b1) begin
         n_dones++;
         last_done_cyc = cyc;
      end
      if (cam_vsync === 1'b1) vs_clks++;
      if (cam_href === 1'b1) begin
         href_clks++;
         if (pclk === 1'b0) bytes_q.push_back(cam_data);
      end
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int n = 0;
      do begin
         step();
         n++;
      end while (busy !== 1'b0 && n < budget);
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic pulse_shot();
      single_shot = 1'b1;
      step();
      single_shot = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; enable = 1'b0; single_shot = 1'b0;
      clear_stats();
      repeat (3) step();
      check("reset_zero", dut_vec(), 32'd0);
      reset = 1'b0;
      step();
      check("pclk_first", {31'd0, pclk}, 32'd1);
      step();
      check("pclk_second", {31'd0, pclk}, 32'd0);
      repeat (4) step();

      // one single-shot frame
      clear_stats();
      pulse_shot();
      run_until_idle("shot1_idle", 400);
      check("shot1_count", 32'(frame_count), 32'd1);
      check("shot1_starts", 32'(n_starts), 32'd1);
      check("shot1_dones", 32'(n_dones), 32'd1);
      check("shot1_len", 32'(last_done_cyc - last_start_cyc), 32'd216);
      check("shot1_vsync", 32'(vs_clks), 32'd36);
      check("shot1_href", 32'(href_clks), 32'd96);
      check("shot1_bytes", 32'(bytes_q.size()), 32'd48);
      if (bytes_q.size() == 48) begin
         for (int i = 0; i < 16; i++) check("line2_byte", 32'(bytes_q[32 + i]), 32'(pattern(2, i)));
`ifndef DVP_TX_COLORBAR_EN
         check("line2_first", 32'(bytes_q[32]), 32'h02);
         check("line2_last", 32'(bytes_q[47]), 32'h11);
`endif
      end
      repeat (300) step();
      check("shot1_no_more", 32'(n_starts), 32'd1);

      // continuous run, enable dropped during frame 3
      reset = 1'b1; step(); reset = 1'b0; step();
      clear_stats();
      enable = 1'b1;
      n = 0;
      do begin step(); n++; end while (n_starts < 3 && n < 1000);
      check("cont_third_start", 32'(n_starts), 32'd3);
      repeat (100) step();
      enable = 1'b0;
      run_until_idle("cont_idle", 600);
      check("cont_count", 32'(frame_count), 32'd3);
      check("cont_dones", 32'(n_dones), 32'd3);
      check("cont_gaps", 32'(gaps.size()), 32'd2);
      foreach (gaps[i]) check("cont_gap", 32'(gaps[i]), 32'd216);
      repeat (300) step();
      check("cont_no_more", 32'(n_starts), 32'd3);

      // two extra shots while busy collapse into one extra frame
      clear_stats();
      pulse_shot();
      repeat (50) step();
      pulse_shot();
      repeat (30) step();
      pulse_shot();
      run_until_idle("queue_idle", 1000);
      check("queue_count", 32'(frame_count), 32'd5);
      check("queue_starts", 32'(n_starts), 32'd2);
      check("queue_dones", 32'(n_dones), 32'd2);

      // reset in the middle of an active line
      clear_stats();
      pulse_shot();
      repeat (150) step();
      check("mid_href_busy", {30'd0, busy, 1'b1}, 32'd3);
      reset = 1'b1;
      step();
      check("mid_reset_zero", dut_vec(), 32'd0);
      reset = 1'b0;
      repeat (300) step();
      check("mid_no_done", 32'(n_dones), 32'd0);
      check("mid_count", 32'(frame_count), 32'd0);

      // random enable / single_shot traffic
      clear_stats();
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 99) < 2) enable = ~enable;
         single_shot = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
         step();
      end
      single_shot = 1'b0;
      enable = 1'b0;
      run_until_idle("rand_idle", 700);
      check("rand_dones", 32'(n_dones), 32'(m_count));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
